// File: rtl/uart_rx_core_if.sv
// CSR-facing signal bundle of the UART receive engine: configuration in, RX buffer/flags out.
// master = the receive engine, slave = the CSR block.
interface uart_rx_core_if #(
    parameter int unsigned CLK_MHZ_W = 8
);
    logic                 en;
    logic [3:0]           br;
    logic [CLK_MHZ_W-1:0] clk_mhz;
    logic                 rd_ack;
    logic [7:0]           rx_data;
    logic                 rxne;
    logic                 ferr;
    logic                 ovr;

    modport master (
        input  en,
        input  br,
        input  clk_mhz,
        input  rd_ack,
        output rx_data,
        output rxne,
        output ferr,
        output ovr
    );

    modport slave (
        output en,
        output br,
        output clk_mhz,
        output rd_ack,
        input  rx_data,
        input  rxne,
        input  ferr,
        input  ovr
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling driven by a phase-accumulator baud tick.
// Optional UART_RX_MAJORITY_EN: each bit decided by a 2-of-3 vote at ticks 7, 8, 9 of the bit.
module uart_rx_core (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    uart_rx_core_if.master bus
);
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] StartPt = 4'd9;
`else
    localparam logic [3:0] StartPt = 4'd7;
`endif
    localparam logic [3:0] BitPt = 4'd15;

    logic [27:0] inc;
    logic [31:0] limit;
    logic [31:0] sum;
    logic [27:0] acc_q;
    logic        tick_q;

    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_prev_q;

    state_e      state_q;
    logic [3:0]  tcnt_q;
    logic [2:0]  bcnt_q;
    logic [7:0]  shift_q;
    logic [3:0]  cur_pt;
    logic        at_pt;
    logic        bit_val;
    logic        ack;

    logic [7:0]  rx_data_q;
    logic        rxne_q;
    logic        ferr_q;
    logic        ovr_q;

    // Increment is 16x the baud rate so one tick is one oversampling slot.
    always_comb begin
        inc = 28'd1843200;
        case (bus.br)
            4'd0:    inc = 28'd19200;
            4'd1:    inc = 28'd38400;
            4'd2:    inc = 28'd76800;
            4'd3:    inc = 28'd153600;
            4'd4:    inc = 28'd307200;
            4'd5:    inc = 28'd614400;
            4'd6:    inc = 28'd921600;
            default: inc = 28'd1843200;
        endcase
    end

    assign limit = 32'(bus.clk_mhz) * 32'd1_000_000;
    assign sum   = {4'b0000, acc_q} + {4'b0000, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else if (!bus.en || bus.clk_mhz == '0) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else if (sum >= limit) begin
            acc_q  <= 28'(sum - limit);
            tick_q <= 1'b1;
        end else begin
            acc_q  <= sum[27:0];
            tick_q <= 1'b0;
        end
    end

    // Idle-high reset values keep a reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign cur_pt = (state_q == StStart) ? StartPt : BitPt;
    assign at_pt  = (tcnt_q == cur_pt);
    assign ack    = bus.rd_ack & rxne_q;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] samp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
        end else if (tick_q && (tcnt_q == cur_pt - 4'd2 || tcnt_q == cur_pt - 4'd1)) begin
            samp_q <= {samp_q[0], rx_sync_q};
        end
    end

    assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync_q) |
                     (samp_q[0] & rx_sync_q);
`else
    assign bit_val = rx_sync_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rxne_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (ack) begin
                rxne_q <= 1'b0;
                ferr_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
            if (!bus.en) begin
                state_q <= StIdle;
                tcnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_prev_q && !rx_sync_q) begin
                            tcnt_q  <= '0;
                            state_q <= StStart;
                        end
                    end
                    StStart: begin
                        if (tick_q) begin
                            if (!at_pt) begin
                                tcnt_q <= tcnt_q + 4'd1;
                            end else if (bit_val) begin
                                state_q <= StIdle;
                            end else begin
                                tcnt_q  <= '0;
                                bcnt_q  <= '0;
                                state_q <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (tick_q) begin
                            if (!at_pt) begin
                                tcnt_q <= tcnt_q + 4'd1;
                            end else begin
                                shift_q <= {bit_val, shift_q[7:1]};
                                tcnt_q  <= '0;
                                bcnt_q  <= bcnt_q + 3'd1;
                                if (bcnt_q == 3'd7) begin
                                    state_q <= StStop;
                                end
                            end
                        end
                    end
                    StStop: begin
                        if (tick_q) begin
                            if (!at_pt) begin
                                tcnt_q <= tcnt_q + 4'd1;
                            end else begin
                                tcnt_q  <= '0;
                                state_q <= StIdle;
                                // A completing byte overrides a same-cycle rd_ack.
                                if (bit_val) begin
                                    rx_data_q <= shift_q;
                                    rxne_q    <= 1'b1;
                                    if (rxne_q && !bus.rd_ack) begin
                                        ovr_q <= 1'b1;
                                    end
                                end else begin
                                    ferr_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rxne    = rxne_q;
    assign bus.ferr    = ferr_q;
    assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames checked
// against a frame-level model of the receive buffer and its flags.
module tb_uart_rx_core;
    logic clk;
    logic rst_n;
    logic rx;

    uart_rx_core_if #(.CLK_MHZ_W(8)) bus ();

    uart_rx_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
    localparam int StopTicks = 154;
`else
    localparam int StopTicks = 152;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_data;
    logic       exp_rxne;
    logic       exp_ferr;
    logic       exp_ovr;
    longint     line_hz;

    function automatic longint baud_of(input logic [3:0] b);
        case (b)
            4'd0:    return 1200;
            4'd1:    return 2400;
            4'd2:    return 4800;
            4'd3:    return 9600;
            4'd4:    return 19200;
            4'd5:    return 38400;
            4'd6:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Tick timing of the baud generator, used only to place rd_ack on the completion edge.
    longint acc_m;
    logic   tick_m;
    longint inc_m;
    longint lim_m;
    assign inc_m = 16 * baud_of(bus.br);
    assign lim_m = longint'(bus.clk_mhz) * 1000000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m  <= 0;
            tick_m <= 1'b0;
        end else if (!bus.en || bus.clk_mhz == 0) begin
            acc_m  <= 0;
            tick_m <= 1'b0;
        end else if (acc_m + inc_m >= lim_m) begin
            acc_m  <= acc_m + inc_m - lim_m;
            tick_m <= 1'b1;
        end else begin
            acc_m  <= acc_m + inc_m;
            tick_m <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq($sformatf("%s.rx_data", tag), 32'(bus.rx_data), 32'(exp_data));
        check_eq($sformatf("%s.rxne", tag), 32'(bus.rxne), 32'(exp_rxne));
        check_eq($sformatf("%s.ferr", tag), 32'(bus.ferr), 32'(exp_ferr));
        check_eq($sformatf("%s.ovr", tag), 32'(bus.ovr), 32'(exp_ovr));
    endtask

    // Buffer/flag rules applied once per received frame.
    function automatic void model_frame(input logic [7:0] d, input logic stop, input logic ack);
        logic ack_eff;
        ack_eff = ack && exp_rxne;
        if (ack_eff) begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end
        if (stop) begin
            if (exp_rxne && !ack) exp_ovr = 1'b1;
            exp_data = d;
            exp_rxne = 1'b1;
        end else begin
            exp_ferr = 1'b1;
            if (ack_eff) exp_rxne = 1'b0;
        end
    endfunction

    function automatic void model_ack();
        if (exp_rxne) begin
            exp_rxne = 1'b0;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [9:0] frame, input int nbits, input int spike_idx);
        longint baud;
        int     n;
        baud = baud_of(bus.br);
        for (int i = 0; i < nbits; i++) begin
            n = int'((longint'(i + 1) * line_hz) / baud - (longint'(i) * line_hz) / baud);
            rx = frame[i];
            if (i == spike_idx) begin
                wait_clks(n / 2);
                rx = ~frame[i];
                wait_clks(1);
                rx = frame[i];
                wait_clks(n - n / 2 - 1);
            end else begin
                wait_clks(n);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_idx);
        drive_bits({stop, d, 1'b0}, 10, spike_idx);
        rx = 1'b1;
        wait_clks(int'(line_hz / baud_of(bus.br)));
    endtask

    task automatic set_cfg(input logic [7:0] mhz, input logic [3:0] b);
        bus.en      = 1'b0;
        bus.clk_mhz = mhz;
        bus.br      = b;
        if (mhz != 0) line_hz = longint'(mhz) * 1000000;
        wait_clks(2);
        bus.en = 1'b1;
        wait_clks(2);
    endtask

    task automatic pulse_ack();
        bus.rd_ack = 1'b1;
        wait_clks(1);
        bus.rd_ack = 1'b0;
        model_ack();
    endtask

    // Raise rd_ack for exactly the cycle whose closing edge samples the stop bit.
    task automatic ack_at_stop();
        int n;
        int budget;
        bit done;
        n = 0;
        budget = 0;
        done = 1'b0;
        wait_clks(3);
        while (!done && budget < 30000) begin
            if (tick_m) n++;
            if (n == StopTicks) begin
                bus.rd_ack = 1'b1;
                wait_clks(1);
                bus.rd_ack = 1'b0;
                done = 1'b1;
                check_eq("coll_edge.rxne", 32'(bus.rxne), 32'd1);
                check_eq("coll_edge.rx_data", 32'(bus.rx_data), 32'h5A);
            end else begin
                wait_clks(1);
            end
            budget++;
        end
        check_eq("coll_ack_timing", 32'(done), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        logic [7:0] mhz_tab [4];
        mhz_tab = '{8'd8, 8'd10, 8'd12, 8'd16};

        rst_n       = 1'b0;
        rx          = 1'b1;
        bus.en      = 1'b0;
        bus.br      = 4'hF;
        bus.clk_mhz = 8'd1;
        bus.rd_ack  = 1'b0;
        line_hz     = 1000000;
        exp_data = 8'h00; exp_rxne = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        check_outputs("reset");

        // Basic receive at 1 MHz / 9600 baud.
        set_cfg(8'd1, 4'd3);
        send_frame(8'hA5, 1'b1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_outputs("basic");
        pulse_ack();
        check_eq("basic_ack.rxne", 32'(bus.rxne), 32'd0);

        // Overrun, then rd_ack colliding with completion.
        send_frame(8'h3C, 1'b1, -1);
        model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, -1);
        model_frame(8'hC3, 1'b1, 1'b0);
        check_outputs("overrun");
        fork
            send_frame(8'h5A, 1'b1, -1);
            ack_at_stop();
        join
        model_frame(8'h5A, 1'b1, 1'b1);
        check_outputs("collision");

        // Frame error at 10 MHz / 115200.
        set_cfg(8'd10, 4'd7);
        send_frame(8'h55, 1'b0, -1);
        model_frame(8'h55, 1'b0, 1'b0);
        check_outputs("ferr");
        pulse_ack();
        check_outputs("ferr_ack");

        // Two-tick low glitch at 1 MHz / 9600.
        set_cfg(8'd1, 4'd3);
        rx = 1'b0;
        wait_clks(13);
        rx = 1'b1;
        wait_clks(250);
        check_outputs("glitch");

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b1, 4);
        model_frame(8'h00, 1'b1, 1'b0);
        check_outputs("spike");
        pulse_ack();
`endif

        // Abort after data bit 4, then a clean frame.
        drive_bits({1'b1, 8'h3F, 1'b0}, 6, -1);
        bus.en = 1'b0;
        rx = 1'b1;
        wait_clks(300);
        check_outputs("abort");
        bus.en = 1'b1;
        wait_clks(20);
        send_frame(8'h81, 1'b1, -1);
        model_frame(8'h81, 1'b1, 1'b0);
        check_outputs("after_abort");

        // Asynchronous reset mid-frame.
        drive_bits({1'b1, 8'h81, 1'b0}, 4, -1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_data = 8'h00; exp_rxne = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        check_outputs("async_rst");
        rx = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);

        // clk_mhz == 0: no ticks, nothing received.
        set_cfg(8'd0, 4'd3);
        send_frame(8'hE7, 1'b1, -1);
        check_outputs("clk0");

        // br = 15 selects 115200.
        set_cfg(8'd10, 4'd15);
        send_frame(8'h6B, 1'b1, -1);
        model_frame(8'h6B, 1'b1, 1'b0);
        check_outputs("br15");

        // Randomized frames, configurations and acks.
        for (int k = 0; k < 6; k++) begin
            set_cfg(mhz_tab[$urandom_range(0, 3)], 4'($urandom_range(5, 15)));
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop, -1);
            model_frame(d, stop, 1'b0);
            check_outputs($sformatf("rand%0d", k));
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                check_eq($sformatf("rand%0d_ack.rxne", k), 32'(bus.rxne), 32'(exp_rxne));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
